// File: rtl/phy_rx_deframer.sv
// -----------------------------------------------------------------------------
// phy_rx_deframer
// Receive-side deframer. Takes the 4-bit nibble stream from the PHY receiver
// (low nibble of each byte first), rebuilds bytes for the forwarding block,
// counts the bytes of each frame and, at end of frame, emits the 24-bit control
// word {len, len} together with a good/bad verdict. Everything is clocked on the
// rising edge of clk_phy.
//
// Parameters
//   MIN_LEN        minimum legal frame length in bytes
//   MAX_LEN        maximum legal frame length in bytes (<= 4094)
//
// Ports
//   clk_phy        in   1   PHY clock
//   reset_n        in   1   asynchronous active-low reset
//   phy_data_in    in   4   received nibble, low nibble of each byte first
//   phy_rx_dv      in   1   nibble valid, high for the whole frame
//   r_data_out     out  8   reassembled byte {hi_nibble, lo_nibble}
//   r_data_valid   out  1   one-cycle pulse per reassembled byte
//   r_ctrl_out     out  24  {len[11:0], len[11:0]}, held until the next frame end
//   r_frame_valid  out  1   one-cycle pulse: frame good, r_ctrl_out valid
//   r_frame_err    out  1   one-cycle pulse: frame bad (length or odd nibble count)
// -----------------------------------------------------------------------------
module phy_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk_phy,
  input  logic        reset_n,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_valid,
  output logic        r_frame_err
);

  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [11:0] LEN_SAT_C = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LO        = 3'd1,
    ST_HI        = 3'd2,
    ST_END       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  lo_nib_r;
  logic [3:0]  lo_nib_s;
  logic [11:0] len_r;
  logic [11:0] len_s;
  logic        odd_r;
  logic        odd_s;
  logic        ovf_r;
  logic        ovf_s;
  // High only in the first cycle after reset release; used to detect that
  // reset was released in the middle of a frame.
  logic        fresh_r;

  logic [7:0]  byte_s;
  logic        byte_valid_s;
  logic [23:0] ctrl_s;
  logic        frame_valid_s;
  logic        frame_err_s;
  logic        frame_good_s;

  // Saturating byte counter increment; the count sticks at 4095.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    logic [11:0] r;
    if (v == LEN_SAT_C) begin
      r = v;
    end else begin
      r = v + 12'd1;
    end
    return r;
  endfunction

  // Verdict for the frame that is closing in the END state.
  assign frame_good_s = !odd_r && (len_r >= MIN_LEN_C) && (len_r <= MAX_LEN_C) && !ovf_r;

  // State register.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus next values for the frame bookkeeping and outputs.
  always_comb begin
    state_s       = state_r;
    lo_nib_s      = lo_nib_r;
    len_s         = len_r;
    odd_s         = odd_r;
    ovf_s         = ovf_r;
    byte_s        = r_data_out;
    byte_valid_s  = 1'b0;
    ctrl_s        = r_ctrl_out;
    frame_valid_s = 1'b0;
    frame_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fresh_r && phy_rx_dv) begin
          // Reset released mid-frame: ignore the remainder of that frame.
          state_s = ST_WAIT_IDLE;
        end else if (phy_rx_dv) begin
          lo_nib_s = phy_data_in;
          len_s    = 12'd0;
          odd_s    = 1'b0;
          ovf_s    = 1'b0;
          state_s  = ST_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HI: begin
        if (phy_rx_dv) begin
          byte_s       = {phy_data_in, lo_nib_r};
          byte_valid_s = 1'b1;
          len_s        = sat_inc(len_r);
          ovf_s        = ovf_r | (len_s == LEN_SAT_C);
          state_s      = ST_LO;
        end else begin
          // Trailing lone nibble: dropped, not counted, frame marked bad.
          odd_s   = 1'b1;
          state_s = ST_END;
        end
      end
      ST_LO: begin
        if (phy_rx_dv) begin
          lo_nib_s = phy_data_in;
          state_s  = ST_HI;
        end else begin
          state_s = ST_END;
        end
      end
      ST_END: begin
        ctrl_s = {len_r, len_r};
        if (frame_good_s) begin
          frame_valid_s = 1'b1;
        end else begin
          frame_err_s = 1'b1;
        end
        // A frame may start right after a one-cycle dv gap; its first nibble
        // arrives during END and must not be lost.
        if (phy_rx_dv) begin
          lo_nib_s = phy_data_in;
          len_s    = 12'd0;
          odd_s    = 1'b0;
          ovf_s    = 1'b0;
          state_s  = ST_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!phy_rx_dv) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame bookkeeping registers.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      lo_nib_r <= 4'd0;
      len_r    <= 12'd0;
      odd_r    <= 1'b0;
      ovf_r    <= 1'b0;
      fresh_r  <= 1'b1;
    end else begin
      lo_nib_r <= lo_nib_s;
      len_r    <= len_s;
      odd_r    <= odd_s;
      ovf_r    <= ovf_s;
      fresh_r  <= 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out    <= 8'd0;
      r_data_valid  <= 1'b0;
      r_ctrl_out    <= 24'd0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_data_out    <= byte_s;
      r_data_valid  <= byte_valid_s;
      r_ctrl_out    <= ctrl_s;
      r_frame_valid <= frame_valid_s;
      r_frame_err   <= frame_err_s;
    end
  end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_deframer
// Directed and randomized frames driven as nibble streams. Expected bytes and
// per-frame results ({len,len}, good/bad) come from a frame-level model kept in
// queues; a monitor collects what the deframer actually produces.
// -----------------------------------------------------------------------------
module tb_phy_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk_phy;
  logic        reset_n;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic [23:0] r_ctrl_out;
  logic        r_frame_valid;
  logic        r_frame_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  obs_bytes[$];
  logic [23:0] obs_ctrl[$];
  logic        obs_good[$];
  logic [7:0]  exp_bytes[$];
  logic [23:0] exp_ctrl[$];
  logic        exp_good[$];
  int          excl_viol = 0;
  int          consec_viol = 0;
  logic        prev_dv = 1'b0;

  phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk_phy      (clk_phy),
    .reset_n      (reset_n),
    .phy_data_in  (phy_data_in),
    .phy_rx_dv    (phy_rx_dv),
    .r_data_out   (r_data_out),
    .r_data_valid (r_data_valid),
    .r_ctrl_out   (r_ctrl_out),
    .r_frame_valid(r_frame_valid),
    .r_frame_err  (r_frame_err)
  );

  initial begin
    clk_phy = 1'b0;
    forever #5 clk_phy = ~clk_phy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Collect outputs away from the active edge.
  always @(negedge clk_phy) begin
    if (r_data_valid) obs_bytes.push_back(r_data_out);
    if (r_frame_valid || r_frame_err) begin
      obs_ctrl.push_back(r_ctrl_out);
      obs_good.push_back(r_frame_valid);
    end
    if (r_frame_valid && r_frame_err) excl_viol++;
    if (r_data_valid && prev_dv) consec_viol++;
    prev_dv = r_data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_nib(input logic [3:0] n);
    @(negedge clk_phy);
    phy_rx_dv   = 1'b1;
    phy_data_in = n;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk_phy);
      phy_rx_dv   = 1'b0;
      phy_data_in = 4'($urandom_range(0, 15));
    end
  endtask

  // Frame-level model: what a frame of nbytes (+ optional lone nibble) yields.
  task automatic model_frame(input int nbytes, input bit odd);
    int          len;
    logic [11:0] l12;
    len = (nbytes > 4095) ? 4095 : nbytes;
    l12 = 12'(len);
    exp_ctrl.push_back({l12, l12});
    exp_good.push_back(!odd && len >= MIN_LEN && len <= MAX_LEN && nbytes < 4095);
  endtask

  // mode 0: random bytes; mode 1: 00 x4, 05 ..., FF x4.
  task automatic send_frame(input int nbytes, input bit odd, input int mode);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      if (mode == 1) b = (i < 4) ? 8'h00 : ((i >= nbytes - 4) ? 8'hFF : 8'h05);
      else           b = 8'($urandom_range(0, 255));
      exp_bytes.push_back(b);
      drive_nib(b[3:0]);
      drive_nib(b[7:4]);
    end
    if (odd) drive_nib(4'($urandom_range(0, 15)));
    model_frame(nbytes, odd);
  endtask

  task automatic check_all(input string tag);
    int bad;
    int n;
    bad = 0;
    chk({tag, " byte_count"}, obs_bytes.size(), exp_bytes.size());
    n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) if (obs_bytes[i] !== exp_bytes[i]) bad++;
    chk({tag, " byte_data_mismatches"}, bad, 0);
    chk({tag, " frame_events"}, obs_ctrl.size(), exp_ctrl.size());
    n = (obs_ctrl.size() < exp_ctrl.size()) ? obs_ctrl.size() : exp_ctrl.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " ctrl"}, {8'h00, obs_ctrl[i]}, {8'h00, exp_ctrl[i]});
      chk({tag, " good"}, {31'd0, obs_good[i]}, {31'd0, exp_good[i]});
    end
    obs_bytes.delete(); exp_bytes.delete();
    obs_ctrl.delete();  exp_ctrl.delete();
    obs_good.delete();  exp_good.delete();
  endtask

  initial begin
    logic [7:0] b5 [512];
    int         nb;
    bit         odd;

    reset_n     = 1'b0;
    phy_rx_dv   = 1'b0;
    phy_data_in = 4'd0;
    repeat (3) @(negedge clk_phy);
    chk("reset r_data_out",    {24'd0, r_data_out},    32'd0);
    chk("reset r_data_valid",  {31'd0, r_data_valid},  32'd0);
    chk("reset r_ctrl_out",    {8'd0, r_ctrl_out},     32'd0);
    chk("reset r_frame_valid", {31'd0, r_frame_valid}, 32'd0);
    chk("reset r_frame_err",   {31'd0, r_frame_err},   32'd0);
    reset_n = 1'b1;
    gap(3);

    // 512-byte patterned frame: good, ctrl 200200.
    send_frame(512, 1'b0, 1);
    gap(5);
    chk("t1 ctrl_literal", {8'd0, r_ctrl_out}, 32'h00200200);
    check_all("t1");
    gap(3);
    chk("t1 ctrl_held", {8'd0, r_ctrl_out}, 32'h00200200);

    // 60-byte runt.
    send_frame(60, 1'b0, 0);
    gap(5);
    chk("t2 ctrl_literal", {8'd0, r_ctrl_out}, 32'h0003C03C);
    check_all("t2");

    // 64 bytes plus a lone nibble.
    send_frame(64, 1'b1, 0);
    gap(5);
    chk("t3 ctrl_literal", {8'd0, r_ctrl_out}, 32'h00040040);
    check_all("t3");

    // Back-to-back 64-byte frames, one idle cycle apart.
    send_frame(64, 1'b0, 0);
    gap(1);
    send_frame(64, 1'b0, 0);
    gap(5);
    check_all("t4");

    // Reset in the middle of byte 100 of a 512-byte frame, released with dv high.
    for (int i = 0; i < 512; i++) b5[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100; i++) exp_bytes.push_back(b5[i]);
    for (int i = 0; i < 1024; i++) begin
      drive_nib((i % 2) ? b5[i / 2][7:4] : b5[i / 2][3:0]);
      if (i == 201) reset_n = 1'b0;
      if (i == 203) chk("t5 ctrl_cleared_by_reset", {8'd0, r_ctrl_out}, 32'd0);
      if (i == 205) reset_n = 1'b1;
    end
    gap(5);
    check_all("t5 aborted");
    send_frame(64, 1'b0, 0);
    gap(5);
    check_all("t5 next");

    // Oversized frame: length saturates.
    send_frame(4100, 1'b0, 0);
    gap(5);
    chk("t6 ctrl_literal", {8'd0, r_ctrl_out}, 32'h00FFFFFF);
    check_all("t6");

    // Randomized lengths around the lower bound, with and without a lone nibble.
    for (int k = 0; k < 8; k++) begin
      nb  = $urandom_range(55, 75);
      odd = 1'($urandom_range(0, 1));
      send_frame(nb, odd, 0);
      gap(5);
      check_all("rand");
    end

    // Upper bound: MAX_LEN good, MAX_LEN+1 bad.
    send_frame(MAX_LEN, 1'b0, 0);
    gap(5);
    check_all("max_len");
    send_frame(MAX_LEN + 1, 1'b0, 0);
    gap(5);
    check_all("max_len_plus1");

    chk("frame_valid_err_exclusive", excl_viol, 0);
    chk("data_valid_not_consecutive", consec_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
